// File: rtl/cpu_mem_pkg.sv
// Shared memory-side types for the CPU data path.
// Word-address helpers and the store buffer entry layout.
package cpu_mem_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int WADDR_W = ADDR_W - 2;

    typedef logic [WADDR_W-1:0] waddr_t;

    typedef struct packed {
        logic              valid;
        waddr_t            word_addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    function automatic waddr_t word_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:2];
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Memory-stage / data-memory bundle around the store buffer.
// master = pipeline + memory side, slave = the buffer itself.
interface store_buffer_if #(
    parameter int DEPTH = 4
);
    import cpu_mem_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              empty;
    logic [CW-1:0]     count;

    modport master (
        output st_valid, st_addr, st_data,
        output ld_valid, ld_addr, mem_ready,
        input  st_ready, ld_hit, ld_data,
        input  mem_we, mem_addr, mem_wdata,
        input  empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_data,
        input  ld_valid, ld_addr, mem_ready,
        output st_ready, ld_hit, ld_data,
        output mem_we, mem_addr, mem_wdata,
        output empty, count
    );

endinterface

// File: rtl/sb_match.sv
// Load lookup across all buffered stores.
// Scans oldest to youngest from head so the youngest match wins.
module sb_match
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  sb_entry_t         ent [DEPTH],
    input  logic [PW-1:0]     head,
    input  logic              ld_valid,
    input  waddr_t            ld_word,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ld_valid &&
                ent[head + PW'(i)].valid &&
                ent[head + PW'(i)].word_addr == ld_word) begin
                hit  = 1'b1;
                data = ent[head + PW'(i)].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order word store buffer between the memory stage and data memory.
// Retires one store per cycle and forwards buffered data to loads.
module store_buffer
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    store_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t     ent [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    waddr_t        ld_word;

    // A full buffer refuses stores even when a drain happens this cycle.
    assign bus.st_ready = count < CW'(DEPTH);
    assign bus.empty    = count == '0;
    assign bus.mem_we   = !bus.empty;
    assign bus.count    = count;

    assign push = bus.st_valid & bus.st_ready;
    assign pop  = bus.mem_we & bus.mem_ready;

    assign bus.mem_addr  = bus.mem_we ?
        {ent[head].word_addr, 2'b00} : '0;
    assign bus.mem_wdata = bus.mem_we ?
        ent[head].data : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            if (push) begin
                ent[tail] <= '{
                    valid:     1'b1,
                    word_addr: word_of(bus.st_addr),
                    data:      bus.st_data
                };
                tail <= tail + PW'(1);
            end
            if (pop) begin
                ent[head].valid <= 1'b0;
                head <= head + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign ld_word = word_of(bus.ld_addr);

    sb_match #(
        .DEPTH(DEPTH)
    ) u_match (
        .ent      (ent),
        .head     (head),
        .ld_valid (bus.ld_valid),
        .ld_word  (ld_word),
        .hit      (bus.ld_hit),
        .data     (bus.ld_data)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: ordering, back-pressure,
// forwarding priority, pointer wrap and reset flush.
module tb_store_buffer;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    store_buffer_if #(.DEPTH(4)) bus ();

    store_buffer #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
    endtask

    logic [31:0] fill_exp [5];

    initial begin
        n_vec = 0;
        n_bad = 0;
        bus.st_valid  = 1'b0;
        bus.st_addr   = '0;
        bus.st_data   = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        bus.mem_ready = 1'b0;

        // reset held with a store offered: nothing may be captured
        reset = 1'b0;
        put(32'h300, 32'h7);
        repeat (2) cyc();
        reset = 1'b1;
        bus.st_valid = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h300;
        settle();
        check("rst_count", 32'(bus.count), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_we", 32'(bus.mem_we), 0);
        check("rst_ready", 32'(bus.st_ready), 1);
        check("rst_maddr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_hit", 32'(bus.ld_hit), 0);
        check("rst_ldata", bus.ld_data, 0);
        bus.ld_valid = 1'b0;
        cyc();
        check("rst_idle_cnt", 32'(bus.count), 0);

        // single store and drain
        put(32'h300, 32'h5);
        bus.mem_ready = 1'b1;
        settle();
        check("one_we_early", 32'(bus.mem_we), 0);
        cyc();
        bus.st_valid = 1'b0;
        settle();
        check("one_we", 32'(bus.mem_we), 1);
        check("one_addr", bus.mem_addr, 32'h300);
        check("one_data", bus.mem_wdata, 32'h5);
        check("one_cnt", 32'(bus.count), 1);
        cyc();
        check("one_empty", 32'(bus.empty), 1);
        check("one_we_off", 32'(bus.mem_we), 0);

        // fill to full with memory stalled
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            put(32'h300 + 32'(4 * k), 32'h10 + 32'(k));
            settle();
            check("fill_ready", 32'(bus.st_ready), 1);
            cyc();
        end
        put(32'h310, 32'h14);
        settle();
        check("full_ready", 32'(bus.st_ready), 0);
        check("full_cnt", 32'(bus.count), 4);
        cyc();
        check("full_hold", 32'(bus.count), 4);
        // drain while the fifth store waits for space
        fill_exp[0] = 32'h300;
        fill_exp[1] = 32'h304;
        fill_exp[2] = 32'h308;
        fill_exp[3] = 32'h30C;
        fill_exp[4] = 32'h310;
        bus.mem_ready = 1'b1;
        settle();
        check("full_drain_rdy", 32'(bus.st_ready), 0);
        for (int i = 0; i < 5; i++) begin
            check("drain_addr", bus.mem_addr, fill_exp[i]);
            check("drain_data", bus.mem_wdata, 32'h10 + 32'(i));
            cyc();
            if (i == 0)
                check("refused_cnt", 32'(bus.count), 3);
            if (i == 1) begin
                check("swap_cnt", 32'(bus.count), 3);
                bus.st_valid = 1'b0;
                settle();
            end
        end
        check("drain_empty", 32'(bus.empty), 1);

        // forwarding priority
        bus.mem_ready = 1'b0;
        put(32'h300, 32'h1);
        cyc();
        put(32'h300, 32'h9);
        cyc();
        bus.st_valid = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h302;
        settle();
        check("fwd_hit", 32'(bus.ld_hit), 1);
        check("fwd_data", bus.ld_data, 32'h9);
        bus.ld_addr = 32'h304;
        settle();
        check("fwd_miss_hit", 32'(bus.ld_hit), 0);
        check("fwd_miss_data", bus.ld_data, 0);
        bus.ld_valid = 1'b0;
        bus.ld_addr  = 32'h300;
        settle();
        check("fwd_gated", 32'(bus.ld_hit), 0);
        check("fwd_gated_d", bus.ld_data, 0);
        // same-cycle store must not forward
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h304;
        put(32'h304, 32'h44);
        settle();
        check("same_cyc_hit", 32'(bus.ld_hit), 0);
        cyc();
        bus.st_valid = 1'b0;
        settle();
        check("next_cyc_hit", 32'(bus.ld_hit), 1);
        check("next_cyc_data", bus.ld_data, 32'h44);
        // entries being drained still forward
        bus.mem_ready = 1'b1;
        bus.ld_addr   = 32'h300;
        settle();
        check("drain_fwd0", bus.ld_data, 32'h9);
        cyc();
        check("drain_fwd1", bus.ld_data, 32'h9);
        check("drain_fwd1_w", bus.mem_wdata, 32'h9);
        cyc();
        check("drained_miss", 32'(bus.ld_hit), 0);
        cyc();
        check("fwd_empty", 32'(bus.empty), 1);
        bus.ld_valid = 1'b0;

        // back-to-back stores with drain: pointers wrap
        for (int k = 0; k < 10; k++) begin
            put(32'h300 + 32'(4 * k), 32'(k));
            settle();
            check("wrap_ready", 32'(bus.st_ready), 1);
            check("wrap_cnt", 32'(bus.count), (k == 0) ? 0 : 1);
            if (k > 0) begin
                check("wrap_we", 32'(bus.mem_we), 1);
                check("wrap_data", bus.mem_wdata, 32'(k - 1));
                check("wrap_addr", bus.mem_addr,
                      32'h300 + 32'(4 * (k - 1)));
            end
            cyc();
        end
        bus.st_valid = 1'b0;
        settle();
        check("wrap_last", bus.mem_wdata, 32'h9);
        cyc();
        check("wrap_empty", 32'(bus.empty), 1);

        // reset discards pending stores
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            put(32'h500 + 32'(4 * k), 32'hA0 + 32'(k));
            cyc();
        end
        bus.st_valid = 1'b0;
        settle();
        check("pend_cnt", 32'(bus.count), 3);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        settle();
        check("flush_cnt", 32'(bus.count), 0);
        check("flush_we", 32'(bus.mem_we), 0);
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("flush_nowr", 32'(bus.mem_we), 0);
        end
        check("flush_ready", 32'(bus.st_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Word-granular FIFO write buffer between the memory stage and data memory.
- Absorbs stores from the memory stage and retires them to data memory one per cycle, in program order, when memory is ready.
- Forwards buffered store data to same-cycle loads, so the memory stage never reads stale data.
- Lets stores to the result matrix (e.g. C region at 0x300) overlap with loop loads.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- ADDR_W, 32, byte address width.
- DATA_W, 32, store data width; word stores only.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; reset=0 at a rising edge clears the block.
- st_valid  in  1  memory stage presents a store this cycle (is_store).
- st_addr  in  ADDR_W  store byte address (ALU result).
- st_data  in  DATA_W  store data (write data).
- st_ready  out  1  buffer accepts the store this cycle.
- ld_valid  in  1  memory stage performs a load this cycle.
- ld_addr  in  ADDR_W  load byte address.
- ld_hit  out  1  a buffered store matches ld_addr.
- ld_data  out  DATA_W  data of the youngest matching entry; 0 when no hit.
- mem_we  out  1  write request to data memory.
- mem_addr  out  ADDR_W  address of the oldest entry.
- mem_wdata  out  DATA_W  data of the oldest entry.
- mem_ready  in  1  data memory commits the write at this edge.
- empty  out  1  no entries held; used by halt/fence logic.
- count  out  clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Storage:
  - Circular array of DEPTH entries {valid, addr[ADDR_W-1:2], data}.
  - head = oldest entry, tail = next free slot; both wrap modulo DEPTH.
  - addr[1:0] are ignored for storage and matching.
- Reset (reset=0 at posedge):
  - head=tail=0, count=0, all valid=0.
  - Outputs after reset: st_ready=1, empty=1, mem_we=0, ld_hit=0, ld_data=0, mem_addr=0, mem_wdata=0.
  - Reset mid-operation discards pending entries without writing them to memory.
- Enqueue:
  - st_ready = (count < DEPTH).
  - When st_valid & st_ready, the entry is written at tail and tail advances.
  - The entry is visible to ld_hit and mem_we from the next cycle.
  - A full buffer refuses the store even if a drain occurs in the same cycle; the upstream stage must stall while st_valid & !st_ready.
- Drain:
  - mem_we = !empty, driven combinationally from head.
  - When mem_we & mem_ready at the edge, head advances and its valid bit clears.
  - Latency: a store enqueued at edge N is presented at edge N+1 at the earliest, committed when mem_ready=1.
- Simultaneous enqueue and drain: count is unchanged; both pointers advance.
- Count and empty:
  - count is registered; empty = (count==0); full = (count==DEPTH).
  - Pointer wrap from DEPTH-1 to 0 must preserve order.
- Load forwarding (combinational):
  - Compares ld_addr[ADDR_W-1:2] against all valid entries.
  - With multiple matches, the youngest (closest to tail) wins.
  - The entry being drained this cycle still forwards.
  - A store enqueued in the same cycle as the load does not forward; the pipeline hazard unit covers that case.
  - ld_hit and ld_data are gated by ld_valid.
- Read-after-write ordering: memory itself is never written out of order, so reads that miss the buffer see committed data.
- No state machine beyond the FIFO pointers; there is no FSM beyond idle/non-empty, which is implied by count.

Decomposition:
- Shared package cpu_mem_pkg:
  - ADDR_W and DATA_W constants.
  - sb_entry_t struct {valid, word_addr, data}.
  - Helper to convert a byte address to a word address.
- Sub-module sb_match: a DEPTH-way comparator plus youngest-match priority encoder, rotated by head. It is the only natural split; the FIFO control stays in store_buffer.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset=0 for 2 cycles with st_valid=1.
  - Response: after release count=0, empty=1, mem_we=0, st_ready=1; no entry is captured during reset.
- Single store and drain:
  - Stimulus: store 0x300/0x00000005, mem_ready=1.
  - Response: next cycle mem_we=1, mem_addr=0x300, mem_wdata=5; the cycle after that, empty=1.
- Fill and back-pressure:
  - Stimulus: mem_ready=0, stores to 0x300, 0x304, 0x308, 0x30C, then 0x310.
  - Response: st_ready=0 on the fifth store and count=4. Raise mem_ready: drain order is 0x300..0x30C, then 0x310 is accepted.
- Forwarding priority:
  - Stimulus: mem_ready=0, store 0x300=1, then 0x300=9, then load 0x302.
  - Response: ld_hit=1, ld_data=9. A load of 0x304 gives ld_hit=0.
- Wrap-around with simultaneous enqueue and drain:
  - Stimulus: mem_ready=1, 10 back-to-back stores to 0x300+4k with data k.
  - Response: count never exceeds 1, st_ready stays 1, and memory receives k=0..9 in order after the pointers wrap.
- Reset mid-operation:
  - Stimulus: 3 entries pending with mem_ready=0, assert reset=0 for 1 cycle.
  - Response: count=0, mem_we=0; subsequent mem_ready=1 produces no writes.
